pipe_hazard_ctrl: RTL and testbench

Central stall/flush sequencer for the 5-stage pipeline. It detects load-use hazards and sequences multi-cycle multiplies held in EX. It converts data-memory wait, branch redirect and multiply occupancy into per-register control: freeze, bubble and flush. It drives the D->EX register's stall_D / MEM_stall / flush inputs, plus the F, F/D and EX/MEM controls, and keeps saturating stall performance counters.

---
 rtl/pipe_pkg.sv | 16 +
 rtl/pipe_hazard_ctrl_if.sv | 41 ++++
 rtl/pipe_hazard_ctrl_sat_counter.sv | 31 +++
 rtl/pipe_hazard_ctrl.sv | 102 ++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 233 +++++++++++++++++++++++
 5 files changed

// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared constants and hazard-cause encoding for the pipeline control
package pipe_pkg;

    localparam logic [4:0] REG_ZERO      = 5'd0;
    localparam int         CNT_W_DEFAULT = 32;

    // Ordered from lowest to highest priority; only the winning cause drives controls
    typedef enum logic [2:0] {
        CAUSE_NONE  = 3'd0,
        CAUSE_LU    = 3'd1,
        CAUSE_TAKEN = 3'd2,
        CAUSE_MUL   = 3'd3,
        CAUSE_MEM   = 3'd4
    } hz_cause_e;

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// rtl/pipe_hazard_ctrl_if.sv - hazard-controller signal bundle between pipeline and sequencer
interface pipe_hazard_ctrl_if #(
    parameter int CNT_W = 32
);
    logic [4:0]       D_rs1;
    logic [4:0]       D_rs2;
    logic             D_use_rs1;
    logic             D_use_rs2;
    logic [4:0]       EX_rd;
    logic             EX_ld;
    logic             EX_we;
    logic             EX_mul;
    logic             EX_taken;
    logic             MEM_req;
    logic             mem_ready;
    logic             stall_F;
    logic             stall_D;
    logic             MEM_stall;
    logic             hold_DX;
    logic             bubble_EM;
    logic             flush_FD;
    logic             flush_EX;
    logic             mul_busy;
    logic [CNT_W-1:0] lu_stall_cnt;
    logic [CNT_W-1:0] mul_stall_cnt;

    modport master (
        output D_rs1, D_rs2, D_use_rs1, D_use_rs2, EX_rd, EX_ld, EX_we,
               EX_mul, EX_taken, MEM_req, mem_ready,
        input  stall_F, stall_D, MEM_stall, hold_DX, bubble_EM, flush_FD,
               flush_EX, mul_busy, lu_stall_cnt, mul_stall_cnt
    );

    modport slave (
        input  D_rs1, D_rs2, D_use_rs1, D_use_rs2, EX_rd, EX_ld, EX_we,
               EX_mul, EX_taken, MEM_req, mem_ready,
        output stall_F, stall_D, MEM_stall, hold_DX, bubble_EM, flush_FD,
               flush_EX, mul_busy, lu_stall_cnt, mul_stall_cnt
    );

endinterface

// File: rtl/pipe_hazard_ctrl_sat_counter.sv
// rtl/pipe_hazard_ctrl_sat_counter.sv - enabled counter with synchronous clear that sticks at all-ones
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         clr_i,
    input  logic         en_i,
    output logic [W-1:0] cnt_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (en_i && (cnt_q != '1)) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (clr_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - load-use / multiply / memory-wait stall and flush sequencer
module pipe_hazard_ctrl
    import pipe_pkg::*;
#(
    parameter int MUL_LAT = 3,
    parameter int CNT_W   = CNT_W_DEFAULT
) (
    input  logic               clk,
    input  logic               rst,
    pipe_hazard_ctrl_if.slave  hz
);

    localparam int              MC_W     = $clog2(MUL_LAT) + 1;
    localparam logic [MC_W-1:0] MUL_LAST = MC_W'(MUL_LAT - 1);

    logic [MC_W-1:0]  mul_cnt_q;
    logic [MC_W-1:0]  mul_cnt_d;
    logic             mem_stall;
    logic             mul_busy;
    logic             rs1_hit;
    logic             rs2_hit;
    logic             lu_hazard;
    hz_cause_e        cause;
    logic [CNT_W-1:0] lu_cnt;
    logic [CNT_W-1:0] mul_cnt_perf;

    always_comb begin
        mem_stall = hz.MEM_req & ~hz.mem_ready;
        mul_busy  = hz.EX_mul & (mul_cnt_q != MUL_LAST);
        rs1_hit   = hz.D_use_rs1 & (hz.D_rs1 == hz.EX_rd);
        rs2_hit   = hz.D_use_rs2 & (hz.D_rs2 == hz.EX_rd);
        lu_hazard = hz.EX_ld & hz.EX_we & (hz.EX_rd != REG_ZERO) & (rs1_hit | rs2_hit);
    end

    // A single winning cause keeps freeze from ever coexisting with flush or bubble-into-EX
    always_comb begin
        cause = CAUSE_NONE;
        if (rst) begin
            cause = CAUSE_NONE;
        end else if (mem_stall) begin
            cause = CAUSE_MEM;
        end else if (mul_busy) begin
            cause = CAUSE_MUL;
        end else if (hz.EX_taken) begin
            cause = CAUSE_TAKEN;
        end else if (lu_hazard) begin
            cause = CAUSE_LU;
        end
    end

    always_comb begin
        mul_cnt_d = mul_cnt_q;
        if (!mem_stall) begin
            if (mul_busy) begin
                mul_cnt_d = mul_cnt_q + MC_W'(1);
            end else if (hz.EX_mul) begin
                mul_cnt_d = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mul_cnt_q <= '0;
        end else begin
            mul_cnt_q <= mul_cnt_d;
        end
    end

    sat_counter #(.W(CNT_W)) u_lu_cnt (
        .clk   (clk),
        .clr_i (rst),
        .en_i  (cause == CAUSE_LU),
        .cnt_o (lu_cnt)
    );

    sat_counter #(.W(CNT_W)) u_mul_cnt (
        .clk   (clk),
        .clr_i (rst),
        .en_i  (cause == CAUSE_MUL),
        .cnt_o (mul_cnt_perf)
    );

    assign hz.MEM_stall     = (cause == CAUSE_MEM);
    assign hz.hold_DX       = (cause == CAUSE_MEM) || (cause == CAUSE_MUL);
    assign hz.bubble_EM     = (cause == CAUSE_MUL);
    assign hz.stall_F       = (cause == CAUSE_MEM) || (cause == CAUSE_MUL) || (cause == CAUSE_LU);
    assign hz.stall_D       = (cause == CAUSE_LU);
    assign hz.flush_FD      = (cause == CAUSE_TAKEN);
    assign hz.flush_EX      = (cause == CAUSE_TAKEN);
    assign hz.mul_busy      = mul_busy & ~rst;
    assign hz.lu_stall_cnt  = rst ? '0 : lu_cnt;
    assign hz.mul_stall_cnt = rst ? '0 : mul_cnt_perf;

    // The decoder never marks one EX instruction as both multiply and redirect
    always @(posedge clk) begin
        if (!rst) begin
            assert (!(hz.EX_mul && hz.EX_taken));
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb/tb_pipe_hazard_ctrl.sv - directed vector and sequence bench for pipe_hazard_ctrl
module tb_pipe_hazard_ctrl;

    localparam int CW = 2;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;

    pipe_hazard_ctrl_if #(.CNT_W(CW)) hz ();

    pipe_hazard_ctrl #(.MUL_LAT(3), .CNT_W(CW)) dut (
        .clk (clk),
        .rst (rst),
        .hz  (hz.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       u1;
        logic       u2;
        logic [4:0] rd;
        logic       ld;
        logic       we;
        logic       taken;
        logic       mreq;
        logic       mrdy;
        logic [7:0] exp;
    } vec_t;

    vec_t vecs [14];

    // {stall_F, stall_D, MEM_stall, hold_DX, bubble_EM, flush_FD, flush_EX, mul_busy}
    function automatic logic [7:0] outs();
        return {hz.stall_F, hz.stall_D, hz.MEM_stall, hz.hold_DX,
                hz.bubble_EM, hz.flush_FD, hz.flush_EX, hz.mul_busy};
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_in();
        hz.D_rs1 = 5'd0; hz.D_rs2 = 5'd0; hz.D_use_rs1 = 1'b0; hz.D_use_rs2 = 1'b0;
        hz.EX_rd = 5'd0; hz.EX_ld = 1'b0; hz.EX_we = 1'b0; hz.EX_mul = 1'b0;
        hz.EX_taken = 1'b0; hz.MEM_req = 1'b0; hz.mem_ready = 1'b0;
    endtask

    task automatic set_lu();
        hz.EX_ld = 1'b1; hz.EX_we = 1'b1; hz.EX_rd = 5'd5;
        hz.D_rs2 = 5'd5; hz.D_use_rs2 = 1'b1;
    endtask

    task automatic chk_outs(input string nm, input logic [7:0] exp);
        @(negedge clk);
        chk(nm, int'(outs()), int'(exp));
    endtask

    logic [7:0] mul_seq [3];

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst = 1'b1;
        clear_in();
        mul_seq[0] = 8'b1001_1001;
        mul_seq[1] = 8'b1001_1001;
        mul_seq[2] = 8'b0000_0000;

        //          rs1    rs2    u1    u2    rd     ld    we    tkn   mreq  mrdy  expected
        vecs[0]  = '{5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'b0000_0000};
        vecs[1]  = '{5'd0, 5'd5, 1'b0, 1'b1, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'b1100_0000};
        vecs[2]  = '{5'd0, 5'd0, 1'b0, 1'b1, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'b0000_0000};
        vecs[3]  = '{5'd7, 5'd0, 1'b1, 1'b0, 5'd7, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'b1100_0000};
        vecs[4]  = '{5'd7, 5'd0, 1'b0, 1'b0, 5'd7, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'b0000_0000};
        vecs[5]  = '{5'd7, 5'd0, 1'b1, 1'b0, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'b0000_0000};
        vecs[6]  = '{5'd7, 5'd0, 1'b1, 1'b0, 5'd7, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'b0000_0000};
        vecs[7]  = '{5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'b0000_0110};
        vecs[8]  = '{5'd0, 5'd5, 1'b0, 1'b1, 5'd5, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'b0000_0110};
        vecs[9]  = '{5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'b1011_0000};
        vecs[10] = '{5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'b0000_0000};
        vecs[11] = '{5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'b1011_0000};
        vecs[12] = '{5'd0, 5'd5, 1'b0, 1'b1, 5'd5, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'b1011_0000};
        vecs[13] = '{5'd0, 5'd5, 1'b0, 1'b1, 5'd6, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'b0000_0000};

        tick();
        tick();
        rst = 1'b0;
        chk_outs("reset_outs", 8'b0);
        chk("reset_lu_cnt", int'(hz.lu_stall_cnt), 0);
        chk("reset_mul_cnt", int'(hz.mul_stall_cnt), 0);
        tick();

        for (int i = 0; i < 14; i++) begin
            hz.D_rs1 = vecs[i].rs1; hz.D_rs2 = vecs[i].rs2;
            hz.D_use_rs1 = vecs[i].u1; hz.D_use_rs2 = vecs[i].u2;
            hz.EX_rd = vecs[i].rd; hz.EX_ld = vecs[i].ld; hz.EX_we = vecs[i].we;
            hz.EX_taken = vecs[i].taken; hz.MEM_req = vecs[i].mreq; hz.mem_ready = vecs[i].mrdy;
            chk_outs($sformatf("vec%0d", i), vecs[i].exp);
            tick();
        end
        clear_in();
        chk_outs("table_lu_cnt", 8'b0);
        chk("table_lu_cnt_val", int'(hz.lu_stall_cnt), 2);

        // Reset asserted with every hazard source active
        rst = 1'b1;
        set_lu();
        hz.EX_mul = 1'b1; hz.MEM_req = 1'b1;
        chk_outs("rst_active_outs", 8'b0);
        chk("rst_active_lu_cnt", int'(hz.lu_stall_cnt), 0);
        tick();
        rst = 1'b0;
        clear_in();
        chk_outs("post_rst_outs", 8'b0);
        chk("post_rst_lu_cnt", int'(hz.lu_stall_cnt), 0);
        tick();

        // Single load-use bubble, then the load has moved to MEM
        set_lu();
        chk_outs("lu_bubble", 8'b1100_0000);
        tick();
        clear_in();
        hz.MEM_req = 1'b1; hz.mem_ready = 1'b1;
        chk_outs("lu_cleared", 8'b0);
        chk("lu_cnt_one", int'(hz.lu_stall_cnt), 1);
        tick();
        clear_in();

        // Three-cycle multiply
        hz.EX_mul = 1'b1;
        for (int i = 0; i < 3; i++) begin
            chk_outs($sformatf("mul_cyc%0d", i), mul_seq[i]);
            tick();
        end
        hz.EX_mul = 1'b0;
        chk_outs("mul_done", 8'b0);
        chk("mul_stall_cnt_2", int'(hz.mul_stall_cnt), 2);
        tick();

        // Multiply interrupted by a four-cycle memory wait in its second cycle
        hz.EX_mul = 1'b1;
        chk_outs("mulmem_c0", 8'b1001_1001);
        tick();
        hz.MEM_req = 1'b1; hz.mem_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk_outs($sformatf("mulmem_wait%0d", i), 8'b1011_0001);
            tick();
        end
        hz.mem_ready = 1'b1;
        chk_outs("mulmem_resume", 8'b1001_1001);
        tick();
        hz.MEM_req = 1'b0;
        chk_outs("mulmem_last", 8'b0);
        tick();
        hz.EX_mul = 1'b0;
        chk_outs("mulmem_idle", 8'b0);
        chk("mul_stall_cnt_sat", int'(hz.mul_stall_cnt), 3);
        tick();

        // Redirect held across a memory wait
        hz.EX_taken = 1'b1; hz.MEM_req = 1'b1; hz.mem_ready = 1'b0;
        chk_outs("redir_frozen0", 8'b1011_0000);
        tick();
        chk_outs("redir_frozen1", 8'b1011_0000);
        tick();
        hz.mem_ready = 1'b1;
        chk_outs("redir_release", 8'b0000_0110);
        tick();
        clear_in();

        // Redirect wins over load-use and does not count a bubble
        set_lu();
        hz.EX_taken = 1'b1;
        chk_outs("redir_vs_lu", 8'b0000_0110);
        tick();
        clear_in();
        chk_outs("redir_vs_lu_idle", 8'b0);
        chk("redir_vs_lu_cnt", int'(hz.lu_stall_cnt), 1);
        tick();

        // Reset in the middle of a multiply abandons it
        hz.EX_mul = 1'b1;
        chk_outs("rstmul_c0", 8'b1001_1001);
        tick();
        rst = 1'b1;
        chk_outs("rstmul_rst_outs", 8'b0);
        chk("rstmul_rst_mulcnt", int'(hz.mul_stall_cnt), 0);
        tick();
        rst = 1'b0;
        chk("rstmul_lu_cnt", int'(hz.lu_stall_cnt), 0);
        for (int i = 0; i < 3; i++) begin
            chk_outs($sformatf("rstmul_cyc%0d", i), mul_seq[i]);
            tick();
        end
        clear_in();
        chk_outs("rstmul_idle", 8'b0);
        chk("rstmul_mulcnt", int'(hz.mul_stall_cnt), 2);
        tick();

        // Five load-use bubbles saturate the 2-bit counter
        set_lu();
        for (int i = 0; i < 5; i++) begin
            chk_outs($sformatf("sat_lu%0d", i), 8'b1100_0000);
            tick();
            if (i == 1) begin
                chk("sat_lu_mid", int'(hz.lu_stall_cnt), 2);
            end
        end
        clear_in();
        chk_outs("sat_idle", 8'b0);
        chk("sat_lu_cnt", int'(hz.lu_stall_cnt), 3);
        tick();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
